// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data share one memory port.
// Ports:
//   clk, rst                              clock, async active-high reset
//   if_req_i, if_addr_i                   fetch read request and address
//   if_gnt_o, if_rvalid_o, if_rdata_o     fetch accept and response
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_be_i                     data request (load/store)
//   d_gnt_o, d_rvalid_o, d_rdata_o        data accept and response
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_be_o                 shared memory request
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory accept and response
//   err_stray_rsp_o                       sticky: response with nothing outstanding
module mem_arbiter #(
    parameter int AWIDTH     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    input  logic [3:0]        d_be_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              err_stray_rsp_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        IDLE,
        WAIT_RSP
    } state_t;

    state_t        state_q;
    logic          owner_q;   // 1 = data owns the outstanding transaction
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          err_q;

    logic idle;
    logic force_if;
    logic sel_d;
    logic grant;
    logic rsp;

    always_comb begin
        // Gate with rst so every handshake output is quiet during reset.
        idle     = (state_q == IDLE) && !rst;
        force_if = (starve_q == SW'(STARVE_MAX));
        // Selection depends only on held requests and the counter, which
        // does not move without a grant, so it stays stable under backpressure.
        sel_d    = d_req_i && !(if_req_i && force_if);

        mem_req_o   = idle && (if_req_i || d_req_i);
        mem_we_o    = sel_d && d_we_i;
        mem_addr_o  = sel_d ? d_addr_i : if_addr_i;
        mem_wdata_o = sel_d ? d_wdata_i : 32'h0;
        mem_be_o    = sel_d ? d_be_i : 4'hF;

        grant    = mem_req_o && mem_gnt_i;
        d_gnt_o  = grant && sel_d;
        if_gnt_o = grant && !sel_d;

        rsp         = (state_q == WAIT_RSP) && !rst && mem_rvalid_i;
        if_rvalid_o = rsp && !owner_q;
        d_rvalid_o  = rsp && owner_q;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'h0;

        err_stray_rsp_o = err_q;

        starve_d = starve_q;
        if (if_gnt_o || !if_req_i) begin
            starve_d = '0;
        end else if (d_gnt_o && !force_if) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    starve_q <= starve_d;
                    if (mem_rvalid_i) begin
                        err_q <= 1'b1;
                    end
                    if (grant) begin
                        owner_q <= sel_d;
                        state_q <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rvalid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rv;
    logic [31:0]   if_rd;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt, d_rv;
    logic [31:0]   d_rd;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_be;
    logic          m_gnt, m_rv;
    logic [31:0]   m_rdata;
    logic          err;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.AWIDTH(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(if_gnt), .if_rvalid_o(if_rv), .if_rdata_o(if_rd),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_be_i(d_be),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rv), .d_rdata_o(d_rd),
        .mem_req_o(m_req), .mem_we_o(m_we), .mem_addr_o(m_addr),
        .mem_wdata_o(m_wdata), .mem_be_o(m_be),
        .mem_gnt_i(m_gnt), .mem_rvalid_i(m_rv), .mem_rdata_i(m_rdata),
        .err_stray_rsp_o(err)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding transaction, who owns it,
    // how many arbitrations fetch has lost in a row, sticky error.
    bit busy;
    bit own_data;
    int lost;
    bit m_err;
    bit e_if_gnt, e_d_gnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        busy = 0;
        own_data = 0;
        lost = 0;
        m_err = 0;
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_mreq"}, 32'(m_req), 0);
        chk({tag, "_ifg"}, 32'(if_gnt), 0);
        chk({tag, "_dg"}, 32'(d_gnt), 0);
        chk({tag, "_ifrv"}, 32'(if_rv), 0);
        chk({tag, "_drv"}, 32'(d_rv), 0);
        chk({tag, "_ifrd"}, if_rd, 0);
        chk({tag, "_drd"}, d_rd, 0);
    endtask

    // Called just after a negedge with inputs applied; ends at next negedge.
    task automatic step();
        bit mreq, fetch_wins, if_win, rsp;
        #1;
        mreq = !busy && (if_req || d_req);
        fetch_wins = if_req && (!d_req || lost >= SMAX);
        e_if_gnt = mreq && m_gnt && fetch_wins;
        e_d_gnt = mreq && m_gnt && !fetch_wins;
        rsp = busy && m_rv;
        chk("mem_req", 32'(m_req), 32'(mreq));
        chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
        chk("d_gnt", 32'(d_gnt), 32'(e_d_gnt));
        chk("if_rvalid", 32'(if_rv), 32'(rsp && !own_data));
        chk("d_rvalid", 32'(d_rv), 32'(rsp && own_data));
        chk("if_rdata", if_rd, (rsp && !own_data) ? m_rdata : 0);
        chk("d_rdata", d_rd, (rsp && own_data) ? m_rdata : 0);
        chk("err", 32'(err), 32'(m_err));
        if (mreq) begin
            chk("mem_addr", m_addr, fetch_wins ? if_addr : d_addr);
            chk("mem_we", 32'(m_we), fetch_wins ? 0 : 32'(d_we));
            chk("mem_wdata", m_wdata, fetch_wins ? 0 : d_wdata);
            chk("mem_be", 32'(m_be), fetch_wins ? 32'hF : 32'(d_be));
        end
        if_win = e_if_gnt;
        @(posedge clk);
        if (!busy) begin
            if (m_rv) m_err = 1;
            if (if_win || !if_req) lost = 0;
            else if (e_d_gnt) lost = (lost < SMAX) ? lost + 1 : SMAX;
            if (e_if_gnt || e_d_gnt) begin
                busy = 1;
                own_data = e_d_gnt;
            end
        end else if (m_rv) begin
            busy = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        if_req = 1; if_addr = 0;
        d_req = 1; d_we = 1; d_addr = 0; d_wdata = 0; d_be = 0;
        m_gnt = 1; m_rv = 1; m_rdata = 32'hFFFF_FFFF;
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        quiet("rst");
        chk("rst_err", 32'(err), 0);
        if_req = 0; d_req = 0; m_gnt = 0; m_rv = 0; m_rdata = 0;
        rst = 0;
        @(negedge clk);

        // Fetch only
        if_req = 1; if_addr = 32'h100; m_gnt = 1;
        #1;
        chk("f_addr", m_addr, 32'h100);
        chk("f_gnt", 32'(if_gnt), 1);
        step();
        if_req = 0; m_gnt = 0;
        step();
        m_rv = 1; m_rdata = 32'h13;
        #1;
        chk("f_rv", 32'(if_rv), 1);
        chk("f_rd", if_rd, 32'h13);
        step();
        m_rv = 0;

        // Contention: data store wins
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h2000;
        d_wdata = 32'hDEADBEEF; d_be = 4'b0011; m_gnt = 1;
        #1;
        chk("c_dgnt", 32'(d_gnt), 1);
        chk("c_we", 32'(m_we), 1);
        chk("c_addr", m_addr, 32'h2000);
        chk("c_wd", m_wdata, 32'hDEADBEEF);
        chk("c_be", 32'(m_be), 32'h3);
        step();
        d_req = 0; m_rv = 1; m_rdata = 32'h0;
        #1;
        chk("c_ack", 32'(d_rv), 1);
        step();
        m_rv = 0;
        #1;
        chk("c_ifgnt", 32'(if_gnt), 1);
        step();
        if_req = 0; m_rv = 1;
        step();
        m_rv = 0;

        // Starvation: 4 data grants, fetch on 5th, then data again
        if_req = 1; d_req = 1; d_we = 0;
        for (int k = 0; k < 6; k++) begin
            m_gnt = 1; m_rv = 0;
            #1;
            chk("s_dgnt", 32'(d_gnt), (k != 4) ? 1 : 0);
            chk("s_ifgnt", 32'(if_gnt), (k == 4) ? 1 : 0);
            step();
            m_rv = 1; m_rdata = 32'(k);
            step();
        end
        if_req = 0; d_req = 0; m_rv = 0;
        step();

        // Backpressure
        d_req = 1; d_we = 0; d_addr = 32'h40; m_gnt = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("b_req", 32'(m_req), 1);
            chk("b_gnt", 32'(d_gnt), 0);
            step();
        end
        m_gnt = 1;
        #1;
        chk("b_gnt4", 32'(d_gnt), 1);
        step();
        d_req = 0; m_gnt = 0;

        // Reset in WAIT_RSP, then late response
        #3 rst = 1; m_rv = 1;
        #1;
        quiet("mid");
        @(negedge clk);
        rst = 0;
        mdl_reset();
        step();
        m_rv = 0;
        #1;
        chk("late_err", 32'(err), 1);
        step();
        step();
        rst = 1;
        #1;
        chk("err_clr", 32'(err), 0);
        @(negedge clk);
        rst = 0;
        mdl_reset();

        // Random traffic
        if_req = 0; d_req = 0; m_rv = 0; m_gnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!if_req && ($urandom_range(0, 2) == 0)) begin
                if_req = 1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req && ($urandom_range(0, 2) == 0)) begin
                d_req = 1;
                d_we = 1'($urandom);
                d_addr = $urandom;
                d_wdata = $urandom;
                d_be = 4'($urandom);
            end
            m_gnt = ($urandom_range(0, 3) != 0);
            m_rdata = $urandom;
            if (busy) m_rv = ($urandom_range(0, 2) != 0);
            else m_rv = ($urandom_range(0, 63) == 0);
            step();
            if (e_if_gnt) if_req = 0;
            if (e_d_gnt) d_req = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
